// File: rtl/cpu_rp2a03_pkg.sv
// Shared constants and state encoding for the RP2A03 DMA controller.
package cpu_rp2a03_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ST_W   = 3;

   typedef logic [ST_W-1:0] dma_state_t;

   localparam dma_state_t ST_IDLE    = 3'd0;
   localparam dma_state_t ST_HALT    = 3'd1;
   localparam dma_state_t ST_ALIGN   = 3'd2;
   localparam dma_state_t ST_GET_DMC = 3'd3;
   localparam dma_state_t ST_GET_OAM = 3'd4;
   localparam dma_state_t ST_PUT_OAM = 3'd5;

   localparam logic [ADDR_W-1:0] OAM_DATA_ADDR    = 16'h2004;
   localparam logic [ADDR_W-1:0] OAM_DMA_REG_ADDR = 16'h4014;
   localparam logic [ADDR_W-1:0] DMC_BASE_ADDR    = 16'h8000;

   // Selects the get-cycle action; DMC always wins over a pending OAM byte.
   function automatic dma_state_t dispatch(input logic dmc_req, input logic oam_req);
      if (dmc_req)      return ST_GET_DMC;
      else if (oam_req) return ST_GET_OAM;
      else              return ST_IDLE;
   endfunction

endpackage

// File: rtl/cpu_rp2a03_dma_controller.sv
// RP2A03 bus-master DMA: halts the CPU and interleaves DMC sample fetches
// with 256-byte OAM sprite copies on get/put cycle parity.
module cpu_rp2a03_dma_controller #(
   parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cpu_rd_cycle_i,
   output logic        cpu_halt_o,
   input  logic        oam_dma_start_i,
   input  logic [7:0]  oam_dma_page_i,
   input  logic        dmc_dma_exe_i,
   input  logic [15:0] dmc_dma_addr_i,
   output logic        dmc_dma_rd_o,
   output logic [7:0]  dmc_dma_rd_data_o,
   output logic [15:0] bus_addr_o,
   output logic        bus_rd_o,
   output logic        bus_wr_o,
   output logic [7:0]  bus_wr_data_o,
   input  logic [7:0]  bus_rd_data_i,
   output logic        dma_active_o
);
   import cpu_rp2a03_pkg::*;

   dma_state_t        state_q, state_d;
   logic              put_q, put_d;
   logic              oam_pend_q, oam_pend_d;
   logic [DATA_W-1:0] oam_cnt_q, oam_cnt_d;
   logic [DATA_W-1:0] page_q, page_d;
   logic [DATA_W-1:0] data_q, data_d;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         put_q      <= 1'b0;
         oam_pend_q <= 1'b0;
         oam_cnt_q  <= '0;
         page_q     <= '0;
         data_q     <= '0;
      end else begin
         put_q      <= put_d;
         oam_pend_q <= oam_pend_d;
         oam_cnt_q  <= oam_cnt_d;
         page_q     <= page_d;
         data_q     <= data_d;
      end
   end

   // Request latching, OAM byte counter and fetched-byte holding register
   always_comb begin
      put_d      = ~put_q;
      oam_pend_d = oam_pend_q;
      oam_cnt_d  = oam_cnt_q;
      page_d     = page_q;
      data_d     = data_q;
      if (oam_dma_start_i && !oam_pend_q) begin
         oam_pend_d = 1'b1;
         page_d     = oam_dma_page_i;
         oam_cnt_d  = '0;
      end
      if (state_q == ST_GET_OAM) data_d = bus_rd_data_i;
      if (state_q == ST_PUT_OAM) begin
         oam_cnt_d = oam_cnt_q + DATA_W'(1);
         if (oam_cnt_q == '1) oam_pend_d = 1'b0;
      end
   end

   // Next-state logic; HALT in a get cycle needs an ALIGN put before the first get
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if ((oam_pend_q || dmc_dma_exe_i) && cpu_rd_cycle_i) state_d = ST_HALT;
         ST_HALT:    state_d = put_q ? dispatch(dmc_dma_exe_i, oam_pend_q) : ST_ALIGN;
         ST_ALIGN:   state_d = dispatch(dmc_dma_exe_i, oam_pend_q);
         ST_GET_DMC: state_d = oam_pend_q ? ST_ALIGN : ST_IDLE;
         ST_GET_OAM: state_d = ST_PUT_OAM;
         ST_PUT_OAM: state_d = dispatch(dmc_dma_exe_i, oam_pend_d);
         default:    state_d = ST_IDLE;
      endcase
   end

   // Bus and handshake outputs decoded from the current state
   always_comb begin
      cpu_halt_o        = (state_q != ST_IDLE);
      dma_active_o      = (state_q != ST_IDLE);
      dmc_dma_rd_o      = 1'b0;
      dmc_dma_rd_data_o = '0;
      bus_addr_o        = '0;
      bus_rd_o          = 1'b0;
      bus_wr_o          = 1'b0;
      bus_wr_data_o     = '0;
      unique case (state_q)
         ST_GET_DMC: begin
            bus_rd_o          = 1'b1;
            bus_addr_o        = dmc_dma_addr_i;
            dmc_dma_rd_o      = 1'b1;
            dmc_dma_rd_data_o = bus_rd_data_i;
         end
         ST_GET_OAM: begin
            bus_rd_o   = 1'b1;
            bus_addr_o = {page_q, oam_cnt_q};
         end
         ST_PUT_OAM: begin
            bus_wr_o      = 1'b1;
            bus_addr_o    = OAM_DATA_ADDR;
            bus_wr_data_o = data_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_rp2a03_dma_controller.sv
// Directed scoreboard bench for the RP2A03 DMA controller.
module tb_cpu_rp2a03_dma_controller;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } xfer_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        cpu_rd_cycle_i;
   logic        cpu_halt_o;
   logic        oam_dma_start_i;
   logic [7:0]  oam_dma_page_i;
   logic        dmc_dma_exe_i;
   logic [15:0] dmc_dma_addr_i;
   logic        dmc_dma_rd_o;
   logic [7:0]  dmc_dma_rd_data_o;
   logic [15:0] bus_addr_o;
   logic        bus_rd_o;
   logic        bus_wr_o;
   logic [7:0]  bus_wr_data_o;
   logic [7:0]  bus_rd_data_i;
   logic        dma_active_o;

   xfer_t       exp_wr_q[$];
   logic [7:0]  exp_dmc_q[$];
   xfer_t       e_wr;
   logic [7:0]  e_dmc;
   int          checks = 0;
   int          errors = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          halt_cnt = 0;
   logic        tb_put = 1'b0;

   always #5 clk = ~clk;

   cpu_rp2a03_dma_controller dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .cpu_rd_cycle_i    (cpu_rd_cycle_i),
      .cpu_halt_o        (cpu_halt_o),
      .oam_dma_start_i   (oam_dma_start_i),
      .oam_dma_page_i    (oam_dma_page_i),
      .dmc_dma_exe_i     (dmc_dma_exe_i),
      .dmc_dma_addr_i    (dmc_dma_addr_i),
      .dmc_dma_rd_o      (dmc_dma_rd_o),
      .dmc_dma_rd_data_o (dmc_dma_rd_data_o),
      .bus_addr_o        (bus_addr_o),
      .bus_rd_o          (bus_rd_o),
      .bus_wr_o          (bus_wr_o),
      .bus_wr_data_o     (bus_wr_data_o),
      .bus_rd_data_i     (bus_rd_data_i),
      .dma_active_o      (dma_active_o)
   );

   // Memory: C000 holds the DMC sample, everything else is low byte ^ 5A
   function automatic logic [7:0] mem_f(input logic [15:0] a);
      if (a == 16'hC000) return 8'hA7;
      return a[7:0] ^ 8'h5A;
   endfunction

   assign bus_rd_data_i = bus_rd_o ? mem_f(bus_addr_o) : 8'h00;

   // Reference get/put parity: toggles every clock, cleared by reset
   always @(posedge clk) tb_put <= rst_i ? 1'b0 : ~tb_put;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor and scoreboard
   always @(negedge clk) begin
      if (rst_i === 1'b0) begin
         if (cpu_halt_o) halt_cnt++;
         if (bus_rd_o) rd_cnt++;
         if (!cpu_halt_o)
            chk("idle_outputs", {12'h0, bus_rd_o, bus_wr_o, dmc_dma_rd_o, dma_active_o, bus_addr_o}, 32'h0);
         if (bus_wr_o) begin
            wr_cnt++;
            checks++;
            assert (exp_wr_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_wr: observed addr %0h data %0h expected none", bus_addr_o, bus_wr_data_o);
            end
            if (exp_wr_q.size() != 0) begin
               e_wr = exp_wr_q.pop_front();
               chk("oam_wr", {8'h0, bus_addr_o, bus_wr_data_o}, {8'h0, e_wr.addr, e_wr.data});
            end
         end
         if (dmc_dma_rd_o) begin
            checks++;
            assert (exp_dmc_q.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_dmc_rd: observed addr %0h expected none", bus_addr_o);
            end
            if (exp_dmc_q.size() != 0) begin
               e_dmc = exp_dmc_q.pop_front();
               chk("dmc_rd", {7'h0, bus_rd_o, bus_addr_o, dmc_dma_rd_data_o}, {7'h0, 1'b1, 16'hC000, e_dmc});
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_put(input logic v);
      for (int i = 0; i < 4 && tb_put !== v; i++) tick();
   endtask

   task automatic wait_halt(input string tag, input logic level, input int max);
      for (int n = 0; n < max && cpu_halt_o !== level; n++) tick();
      checks++;
      assert (cpu_halt_o === level) else begin
         errors++;
         $error("FAIL %s: halt observed %0b expected %0b within %0d cycles", tag, cpu_halt_o, level, max);
      end
   endtask

   task automatic push_oam();
      for (int i = 0; i < 256; i++) exp_wr_q.push_back('{addr: 16'h2004, data: 8'(i) ^ 8'h5A});
   endtask

   task automatic start_oam(input logic [7:0] page, input logic want_put);
      push_oam();
      wait_put(want_put);
      halt_cnt = 0;
      wr_cnt   = 0;
      rd_cnt   = 0;
      oam_dma_page_i  = page;
      oam_dma_start_i = 1'b1;
      tick();
      oam_dma_start_i = 1'b0;
   endtask

   task automatic run_oam(input string tag, input logic [7:0] page, input logic want_put, input int exp_halt);
      start_oam(page, want_put);
      wait_halt({tag, "_start"}, 1'b1, 10);
      wait_halt({tag, "_end"}, 1'b0, 700);
      chk({tag, "_halt_cycles"}, 32'(halt_cnt), 32'(exp_halt));
      chk({tag, "_writes"}, 32'(wr_cnt), 32'd256);
      chk({tag, "_reads"}, 32'(rd_cnt), 32'd256);
      chk({tag, "_queue_empty"}, 32'(exp_wr_q.size()), 32'd0);
   endtask

   // Raise a DMC request when parity is want_put; release it right after delivery
   task automatic run_dmc(input string tag, input logic want_put, input int exp_halt);
      int n;
      wait_put(want_put);
      halt_cnt = 0;
      rd_cnt   = 0;
      exp_dmc_q.push_back(8'hA7);
      dmc_dma_addr_i = 16'hC000;
      dmc_dma_exe_i  = 1'b1;
      n = 0;
      while (dmc_dma_rd_o !== 1'b1 && n < 10) begin tick(); n++; end
      chk({tag, "_delivered"}, 32'(dmc_dma_rd_o), 32'd1);
      dmc_dma_exe_i = 1'b0;
      wait_halt({tag, "_end"}, 1'b0, 10);
      chk({tag, "_halt_cycles"}, 32'(halt_cnt), 32'(exp_halt));
      chk({tag, "_reads"}, 32'(rd_cnt), 32'd1);
      chk({tag, "_queue_empty"}, 32'(exp_dmc_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      rst_i           = 1'b1;
      cpu_rd_cycle_i  = 1'b1;
      oam_dma_start_i = 1'b0;
      oam_dma_page_i  = 8'h00;
      dmc_dma_exe_i   = 1'b0;
      dmc_dma_addr_i  = 16'h0000;
      tick(); tick(); tick();
      chk("reset_outputs", {6'h0, cpu_halt_o, dma_active_o, bus_rd_o, bus_wr_o, dmc_dma_rd_o, bus_wr_data_o, bus_addr_o[12:0]}, 32'h0);
      chk("reset_addr", {16'h0, bus_addr_o}, 32'h0);
      rst_i = 1'b0;
      tick(); tick();

      run_oam("oam_align", 8'h02, 1'b0, 514);
      tick(); tick();
      run_oam("oam_noalign", 8'h02, 1'b1, 513);
      tick(); tick();

      run_dmc("dmc_put", 1'b0, 2);
      tick(); tick();
      run_dmc("dmc_get", 1'b1, 3);
      tick(); tick();

      // DMC request lands on OAM byte 100: GET_DMC right after the put, then ALIGN
      start_oam(8'h02, 1'b1);
      n = 0;
      while (wr_cnt < 100 && n < 400) begin tick(); n++; end
      chk("steal_reach_byte100", 32'(wr_cnt), 32'd100);
      chk("steal_on_put", 32'(bus_wr_o), 32'd1);
      exp_dmc_q.push_back(8'hA7);
      dmc_dma_addr_i = 16'hC000;
      dmc_dma_exe_i  = 1'b1;
      tick();
      chk("steal_get_dmc", {30'h0, dmc_dma_rd_o, bus_rd_o}, 32'h3);
      dmc_dma_exe_i = 1'b0;
      tick();
      chk("steal_align", {29'h0, cpu_halt_o, bus_rd_o, bus_wr_o}, 32'h4);
      wait_halt("steal_end", 1'b0, 700);
      chk("steal_halt_cycles", 32'(halt_cnt), 32'd515);
      chk("steal_writes", 32'(wr_cnt), 32'd256);
      chk("steal_queues_empty", 32'(exp_wr_q.size() + exp_dmc_q.size()), 32'd0);
      tick(); tick();

      // Request held off by CPU write cycles, then withdrawn during ALIGN
      rd_cnt = 0;
      cpu_rd_cycle_i = 1'b0;
      dmc_dma_addr_i = 16'hC000;
      dmc_dma_exe_i  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_write_no_halt", 32'(cpu_halt_o), 32'd0);
      end
      wait_put(1'b1);
      chk("wait_write_still_idle", 32'(cpu_halt_o), 32'd0);
      cpu_rd_cycle_i = 1'b1;
      tick();
      chk("withdraw_halt", {29'h0, cpu_halt_o, bus_rd_o, bus_wr_o}, 32'h4);
      dmc_dma_exe_i = 1'b0;
      tick();
      chk("withdraw_align", {29'h0, cpu_halt_o, bus_rd_o, bus_wr_o}, 32'h4);
      tick();
      chk("withdraw_idle", 32'(cpu_halt_o), 32'd0);
      chk("withdraw_no_read", 32'(rd_cnt), 32'd0);
      tick(); tick();

      // Reset in the middle of an OAM copy, then a fresh copy from byte 0
      start_oam(8'h02, 1'b0);
      n = 0;
      while (wr_cnt < 37 && n < 200) begin tick(); n++; end
      chk("rst_reach_byte37", 32'(wr_cnt), 32'd37);
      rst_i = 1'b1;
      tick();
      chk("rst_mid_outputs", {12'h0, cpu_halt_o, dma_active_o, bus_rd_o, bus_wr_o, bus_addr_o}, 32'h0);
      chk("rst_mid_data", {16'h0, bus_wr_data_o, dmc_dma_rd_data_o}, 32'h0);
      rst_i = 1'b0;
      exp_wr_q.delete();
      tick();
      chk("rst_stays_idle", 32'(cpu_halt_o), 32'd0);
      run_oam("oam_restart", 8'h03, 1'b0, 514);
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_rp2a03_dma_controller.md
Name: cpu_rp2a03_dma_controller

Overview:
- Bus-master DMA engine of the RP2A03 core.
- Services the DMC channel's sample-fetch request (exe/addr in; rd strobe and data out) and the OAM sprite DMA triggered by a $4014 write.
- Halts the 6502 core, takes over the CPU bus, and schedules transfers on get/put cycle parity.
- One clk_i cycle = one CPU cycle.

Parameters:
- OAM_DATA_ADDR, 16'h2004, bus write target for OAM DMA.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_rd_cycle_i  in  1  CPU performs a read this cycle; halt may only begin on such a cycle
- cpu_halt_o  out  1  CPU must freeze; DMA owns the bus
- oam_dma_start_i  in  1  one-cycle strobe, CPU write to $4014
- oam_dma_page_i  in  8  source page, valid with the start strobe
- dmc_dma_exe_i  in  1  DMC channel requests one byte (level)
- dmc_dma_addr_i  in  16  DMC fetch address
- dmc_dma_rd_o  out  1  byte delivered to DMC this cycle
- dmc_dma_rd_data_o  out  8  delivered byte
- bus_addr_o  out  16  DMA bus address
- bus_rd_o  out  1  DMA bus read
- bus_wr_o  out  1  DMA bus write
- bus_wr_data_o  out  8  DMA write data
- bus_rd_data_i  in  8  read data, valid in the same cycle as bus_rd_o
- dma_active_o  out  1  state != IDLE

Behaviour:
- Clock and reset:
  - Single clock clk_i. Reset rst_i is synchronous, active-high.
  - On reset: state=IDLE, put_r=0, oam_pend_r=0, oam_cnt_r=0, data_r=0.
  - On reset: all outputs 0, cpu_halt_o released in the cycle after reset is sampled, including mid-transfer.
- Parity:
  - put_r toggles every clock.
  - put_r=0 is a get cycle (reads); put_r=1 is a put cycle (writes).
- Request latching:
  - oam_dma_start_i sets oam_pend_r, loads page_r, clears oam_cnt_r.
  - A start strobe while an OAM DMA is already active is ignored.
  - DMC pending is dmc_dma_exe_i, level-sampled.
- States: IDLE, HALT, ALIGN, GET_DMC, GET_OAM, PUT_OAM.
- IDLE -> HALT: when (oam_pend_r | dmc_dma_exe_i) & cpu_rd_cycle_i. Requests wait while the CPU writes.
- cpu_halt_o is high in every non-IDLE state.
- HALT: dummy cycle, bus idle.
  - put_r=1 (next is get): go to dispatch.
  - put_r=0: go to ALIGN.
- ALIGN: idle put cycle, then dispatch.
- Dispatch (entry to a get cycle), in priority order:
  - dmc_dma_exe_i -> GET_DMC
  - else oam_pend_r -> GET_OAM
  - else -> IDLE (request withdrawn, e.g. DMC disabled; no read issued).
- GET_DMC:
  - bus_rd_o=1, bus_addr_o=dmc_dma_addr_i.
  - dmc_dma_rd_o=1 combinationally in the same cycle, dmc_dma_rd_data_o=bus_rd_data_i.
  - Next: ALIGN if oam_pend_r, else IDLE.
- GET_OAM:
  - bus_rd_o=1, bus_addr_o={page_r, oam_cnt_r}; data_r<=bus_rd_data_i.
  - Always -> PUT_OAM; a DMC request waits for the next get.
- PUT_OAM:
  - bus_wr_o=1, bus_addr_o=OAM_DATA_ADDR, bus_wr_data_o=data_r.
  - oam_cnt_r increments, 8-bit.
  - If oam_cnt_r==255 before the increment: clear oam_pend_r.
  - Then dispatch.
- Cycle counts:
  - OAM alone: 1 halt + optional 1 align + 512 = 513 or 514.
  - DMC alone: 2 or 3.
  - DMC during OAM: steals exactly 2 cycles (GET_DMC + ALIGN).
  - DMC arriving during the final PUT_OAM is served directly, with no extra halt.
- Outputs outside their states are 0; bus_addr_o is 0 when idle.
- dmc_dma_exe_i drops the cycle after dmc_dma_rd_o, because the channel buffer is filled. Only one byte is fetched per request.

Decomposition:
- Shared package cpu_rp2a03_pkg:
  - state encoding localparams;
  - OAM_DATA_ADDR;
  - OAM_DMA_REG_ADDR 16'h4014;
  - DMC base 16'h8000.
- No sub-module; the FSM plus counters fit in a single module (~200 lines).

Test Plan:
- OAM start page 8'h02 with put_r=0 at halt (align needed), RAM[0x0200+i]=i^8'h5A -> 256 writes to 16'h2004 with data i^8'h5A, in ascending order; halt high exactly 514 cycles.
- Same with put_r=1 at halt -> halt high exactly 513 cycles; no align cycle.
- DMC exe with addr 16'hC000, mem=8'hA7, CPU idle-reading -> one bus_rd at C000; dmc_dma_rd_o pulse with data 8'hA7; halt 2 or 3 cycles matching parity.
- DMC exe raised during OAM byte 100 -> GET_DMC on the next get after a PUT_OAM, then ALIGN; OAM sequence intact; total halt = baseline+2.
- Request while cpu_rd_cycle_i=0 for 3 cycles -> halt asserted only after the first read cycle; dmc_dma_exe_i dropped during ALIGN -> return to IDLE, no bus_rd.
- rst_i asserted mid-OAM (cnt=37) -> next cycle IDLE, halt=0, all bus outputs 0; a new start restarts from cnt=0.
